// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave receive path (spi_rx, spi_slave, spi_rx_fifo).
package spi_pkg;

  localparam int unsigned SPI_WORD_LEN = 8;

  typedef logic [SPI_WORD_LEN-1:0] word_t;

  // Address width for an n-entry store, never less than one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pos_edge_det.sv
// Registered rising-edge detector: pulse is high for the one cycle where sig is 1 and was 0.
module pos_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic sig_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q <= 1'b0;
    end else begin
      sig_q <= sig;
    end
  end

  assign pulse = sig & ~sig_q;

endmodule

// File: rtl/spi_rx_fifo.sv
// Receive FIFO behind the SPI slave: one entry per rising edge of recv_data_rdy, show-ahead read.
// Define SPI_RX_FIFO_SYNC_EN to pass recv_data_rdy through a 2-flop synchronizer first.
module spi_rx_fifo
  import spi_pkg::*;
#(
  parameter int unsigned DATA_LEN = SPI_WORD_LEN,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned CNT_W    = clog2_min1(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_LEN-1:0] recv_data,
  input  logic                recv_data_rdy,
  input  logic                rd_en,
  output logic [DATA_LEN-1:0] rd_data,
  output logic                rd_valid,
  output logic                full,
  output logic [CNT_W-1:0]    count,
  output logic                overflow,
  input  logic                ovf_clr
);

  localparam int unsigned PTR_W = clog2_min1(DEPTH);

  logic                rdy_int;
  logic                push_evt;
  logic                pop;
  logic                push_ok;
  logic                ovf_evt;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                overflow_q, overflow_d;
  logic [DATA_LEN-1:0] mem [DEPTH];

`ifdef SPI_RX_FIFO_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], recv_data_rdy};
    end
  end

  assign rdy_int = sync_q[1];
`else
  assign rdy_int = recv_data_rdy;
`endif

  pos_edge_det u_rdy_edge (
    .clk   (clk),
    .rst   (rst),
    .sig   (rdy_int),
    .pulse (push_evt)
  );

  assign rd_valid = (count_q != '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign count    = count_q;
  assign overflow = overflow_q;

  // Empty reads as zero so the output never shows stale or uninitialised memory.
  assign rd_data  = rd_valid ? mem[rd_ptr_q] : '0;

  always_comb begin
    pop        = rd_en & rd_valid;
    // A same-cycle pop frees the slot, so a push into a full FIFO still lands.
    push_ok    = push_evt & (~full | pop);
    ovf_evt    = push_evt & full & ~pop;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
    overflow_d = overflow_q;
    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (ovf_evt) begin
      overflow_d = 1'b1;
    end else if (ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= recv_data;
    end
  end

endmodule

// File: doc/spi_rx_fifo.md
Name: spi_rx_fifo

Overview:
Downstream consumer of the SPI slave receive path.
- Captures each completed receive word, i.e. `recv_data` qualified by a rising edge of `recv_data_rdy`, into a circular buffer.
- Presents buffered words to the MCU-side logic through a show-ahead valid/read handshake.
- Absorbs bursts of SPI frames while the consumer is busy, and flags any words lost to overflow.

Parameters:
- DATA_LEN, 8, width of one received word; must match the slave's RECV_DATA_LEN.
- DEPTH, 8, number of entries; power of two, 2..256.
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- recv_data  input  DATA_LEN  word from the SPI slave; stable while recv_data_rdy is high.
- recv_data_rdy  input  1  level from the SPI slave; a rising edge marks one new word.
- rd_en  input  1  consumer pops the head word in this cycle.
- rd_data  output  DATA_LEN  head word (show-ahead); valid only while rd_valid=1.
- rd_valid  output  1  FIFO not empty.
- full  output  1  count == DEPTH.
- count  output  CNT_W  current occupancy, 0..DEPTH.
- overflow  output  1  sticky; set when a word is dropped because the FIFO is full.
- ovf_clr  input  1  clears overflow.

Behaviour:
- Reset (rst=0, asynchronous, takes effect immediately):
  - wr_ptr, rd_ptr and count go to 0; rd_valid=0, full=0, overflow=0.
  - rd_data=0; memory contents are don't-care.
  - The edge-detect history register goes to 0.
  - After rst deasserts, if recv_data_rdy is already high, the history register (0) makes the first cycle look like a rising edge and one push is taken.
- Push event: push_evt is a one-cycle pulse, registered edge detect (rdy & ~rdy_q).
  - Captured word = recv_data sampled in the push_evt cycle.
  - It is visible on rd_data/rd_valid the cycle after the push_evt cycle.
  - Edge-to-visible latency = 1 clk (macro off).
- Pop: rd_en && rd_valid advances rd_ptr and decrements count at the clock edge. rd_en while empty is ignored: no pointer change, no error.
- Full: push_evt while full with no pop in the same cycle drops the word. overflow is set, and pointers and count are unchanged.
- Simultaneous push_evt and valid pop:
  - Not full: both happen and count is unchanged.
  - Full: the pop frees a slot, so the push is accepted, count stays DEPTH and overflow is not set.
  - Empty: the pop is ignored (rd_valid=0), the push is accepted and count becomes 1. There is no bypass; the data appears next cycle.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. full and rd_valid are derived from count, not from pointer comparison.
- rd_data is read combinationally from mem[rd_ptr]. It must not glitch to a new value except on a pop or on a push-into-empty.
- Overflow flag:
  - ovf_clr clears it next cycle.
  - If ovf_clr and an overflow event coincide, set wins.
- There is no FSM beyond the pointer/count state; no write-side handshake exists. The SPI slave cannot be back-pressured.

Optional Feature:
Macro SPI_RX_FIFO_SYNC_EN.
- Defined:
  - recv_data_rdy passes through a 2-flop synchronizer, reset to 0, before the edge detector.
  - recv_data is captured in the cycle push_evt is asserted, 2 clk after the raw edge. The upstream guarantee covers this: data is held while rdy is high.
  - Edge-to-visible latency = 3 clk.
  - Used when the slave runs on a different clock.
- Undefined: no synchronizer; latency 1 clk as above.

Decomposition:
- Package spi_pkg holds:
  - SPI_WORD_LEN (default 8), shared by spi_rx, spi_slave and this block;
  - function clog2_min1 for CNT_W;
  - no typedefs beyond word_t [SPI_WORD_LEN-1:0].
- Sub-module: reuse the existing pos_edge_det for push_evt; the sync stages live inline under the macro.
- Storage is an inferred reg array in this module; no separate RAM module.

Test Plan:
- Reset, then 3 rdy pulses with words 0xA1, 0xB2, 0xC3, no reads → count=3, rd_data=0xA1, rd_valid=1. Three rd_en pulses → rd_data sequence 0xA1, 0xB2, 0xC3, then rd_valid=0, count=0.
- DEPTH=8: push 9 words 0x01..0x09 → full=1, count=8, overflow=1. Reads return 0x01..0x08; 0x09 is lost. ovf_clr → overflow=0.
- Full FIFO, push_evt and rd_en in the same cycle with word 0x5A → count stays 8, overflow=0. After draining, 0x5A is the last word out.
- Empty FIFO, push_evt and rd_en in the same cycle with 0x33 → count=1, rd_valid=1 next cycle, rd_data=0x33.
- Drive rst low mid-burst, asynchronously between clock edges with count=5 → count=0, rd_valid=0, overflow=0 before the next clk edge. Next push is stored at entry 0 and read back correctly.
- Pointer wrap: 20 interleaved push/pop pairs with incrementing data → output order matches input exactly, count never exceeds 1.
- With SPI_RX_FIFO_SYNC_EN: rdy rising edge with 0x7E → rd_valid rises exactly 3 clk later, rd_data=0x7E.
